// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters.
// Data has priority; fetch wins after MAX_STREAK data grants.
// Ports:
//   clk, reset (sync, active-low)
//   if_*  : fetch request in; ack/err/rdata/stall out
//   d_*   : data request in; ack/err/rdata/stall out
//   mem_* : registered request out; rdata/ready in
//   bus_err_flag : sticky timeout indicator
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 16,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic          if_err,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_ack,
  output logic          d_err,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          bus_err_flag
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SMAX  = SW'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_D  = 2'd1,
    BUSY_IF = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [SW-1:0] streak;

  logic busy_d;
  logic busy_if;
  logic last;
  logic if_win;

  assign busy_d  = (state == BUSY_D);
  assign busy_if = (state == BUSY_IF);
  assign last    = (wait_cnt == CLAST);

  // Fetch only beats a pending data request once the streak is full.
  assign if_win = if_req & (~d_req | (streak == SMAX));

  // mem_ready on the last wait cycle counts as completion, not timeout.
  assign if_ack = busy_if & mem_ready;
  assign d_ack  = busy_d & mem_ready;
  assign if_err = busy_if & ~mem_ready & last;
  assign d_err  = busy_d & ~mem_ready & last;

  assign if_rdata = if_ack ? mem_rdata : '0;
  assign d_rdata  = d_ack ? mem_rdata : '0;

  assign if_stall = if_req & ~if_ack & ~if_err;
  assign d_stall  = d_req & ~d_ack & ~d_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_w        <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= 4'h0;
      wait_cnt     <= '0;
      streak       <= '0;
      bus_err_flag <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_req | d_req) begin
            mem_req  <= 1'b1;
            wait_cnt <= '0;
            if (if_win) begin
              state     <= BUSY_IF;
              mem_w     <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= 4'hF;
              streak    <= '0;
            end else begin
              state     <= BUSY_D;
              mem_w     <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_be    <= d_be;
              if (!if_req)
                streak <= '0;
              else if (streak != SMAX)
                streak <= streak + 1'b1;
            end
          end
        end
        BUSY_D, BUSY_IF: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else if (last) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            bus_err_flag <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
